// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings used by the control decoder, the FSM
// state enum, and the default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH_DEF = 32;

  // Operation select as presented on op_i.
  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the execute stage and mdu_iter.
// Signals:
//   start_i, op_i, data0_i, data1_i  - operation launch and operands
//   hi_we_i, lo_we_i, wdata_i        - MTHI/MTLO write path
//   busy_o, done_o, hi_o, lo_o       - status and architectural HI/LO
// Modports: master (the core side), slave (the unit).
interface mdu_iter_if #(
  parameter int WIDTH = mdu_pkg::MDU_WIDTH_DEF
) ();

  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] data0_i;
  logic [WIDTH-1:0] data1_i;
  logic             hi_we_i;
  logic             lo_we_i;
  logic [WIDTH-1:0] wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, data0_i, data1_i, hi_we_i, lo_we_i, wdata_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, data0_i, data1_i, hi_we_i, lo_we_i, wdata_i,
    output busy_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement of a WIDTH-bit value.
// Ports:
//   en - negate when high, pass through when low
//   a  - input value
//   y  - result
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operands are reduced to magnitudes on launch, processed one radix-2 step
// per clock (shift-add multiply, restoring divide), then sign-corrected in
// a single FIXUP cycle that also loads HI/LO.
// Ports:
//   clk_i - clock, rst_i - asynchronous active-high reset
//   bus   - mdu_iter_if slave modport (launch, MTHI/MTLO, status, HI/LO)
// Optional build macro MDU_FAST_MUL_EN: multiplies complete combinationally
// on the start edge (IDLE -> DONE); divides are unaffected.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEF
) (
  input logic       clk_i,
  input logic       rst_i,
  mdu_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state, state_next;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic               is_div_q, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;

  // Control decoder.
  mdu_op_e op;
  logic    op_div, op_signed;
  always_comb begin
    op        = mdu_op_e'(bus.op_i);
    op_div    = (op == MDU_DIVU) || (op == MDU_DIV);
    op_signed = (op == MDU_MULT) || (op == MDU_DIV);
  end

  // Operand magnitudes taken on the start edge.
  logic [WIDTH-1:0] mag0, mag1;
  mdu_negate #(.WIDTH(WIDTH)) u_mag0 (
    .en(op_signed & bus.data0_i[WIDTH-1]), .a(bus.data0_i), .y(mag0));
  mdu_negate #(.WIDTH(WIDTH)) u_mag1 (
    .en(op_signed & bus.data1_i[WIDTH-1]), .a(bus.data1_i), .y(mag1));

  // Sign correction applied on the FIXUP edge.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  mdu_negate #(.WIDTH(2*WIDTH)) u_prod (.en(neg_res), .a(acc), .y(prod_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_quot (
    .en(neg_res), .a(acc[WIDTH-1:0]), .y(quot_fix));
  mdu_negate #(.WIDTH(WIDTH)) u_rem (
    .en(neg_rem), .a(acc[2*WIDTH-1:WIDTH]), .y(rem_fix));

  // One radix-2 step. acc holds {partial product, multiplier} for multiply
  // and {remainder, dividend/quotient} for divide; opnd holds the other
  // operand magnitude. The divide trial is WIDTH+1 bits so its top bit is
  // the borrow that decides whether to restore.
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] step;
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div_q) begin
      if (!trial[WIDTH]) step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      step = {sum, acc[WIDTH-1:1]};
    end
  end

  // Result selection. A zero divisor forces an all-ones quotient; the
  // remainder path already yields the dividend in that case.
  logic [WIDTH-1:0] res_hi, res_lo;
  always_comb begin
    if (is_div_q) begin
      res_lo = div_zero ? '1 : quot_fix;
      res_hi = rem_fix;
    end else begin
      {res_hi, res_lo} = prod_fix;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext0, ext1, fast_prod;
  assign ext0 = op_signed ? {{WIDTH{bus.data0_i[WIDTH-1]}}, bus.data0_i}
                          : {{WIDTH{1'b0}}, bus.data0_i};
  assign ext1 = op_signed ? {{WIDTH{bus.data1_i[WIDTH-1]}}, bus.data1_i}
                          : {{WIDTH{1'b0}}, bus.data1_i};
  assign fast_prod = ext0 * ext1;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
`ifdef MDU_FAST_MUL_EN
          state_next = op_div ? CALC : DONE;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs.
  logic busy, done;
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Working registers: latch magnitudes and sign flags on launch, then
  // iterate while in CALC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            acc      <= {{WIDTH{1'b0}}, (op_div ? mag0 : mag1)};
            opnd     <= op_div ? mag1 : mag0;
            cnt      <= '0;
            is_div_q <= op_div;
            neg_res  <= op_signed & (bus.data0_i[WIDTH-1] ^ bus.data1_i[WIDTH-1]);
            neg_rem  <= op_signed & bus.data0_i[WIDTH-1];
            div_zero <= (bus.data1_i == '0);
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: the result load on DONE entry beats any same-edge MTHI/MTLO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == FIXUP) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
`ifdef MDU_FAST_MUL_EN
    else if (state == IDLE && bus.start_i && !op_div) begin
      hi_q <= fast_prod[2*WIDTH-1:WIDTH];
      lo_q <= fast_prod[WIDTH-1:0];
    end
`endif
    else begin
      if (bus.hi_we_i) hi_q <= bus.wdata_i;
      if (bus.lo_we_i) lo_q <= bus.wdata_i;
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32). Directed cases
// followed by randomized operations compared against a plain-arithmetic
// reference model, then a mid-operation reset.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [W-1:0] modelHi = '0;
  logic [W-1:0] modelLo = '0;

  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from 64-bit / signed integer arithmetic.
  function automatic void computeRef(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = {32'h0, a} * {32'h0, b}; {hi, lo} = p; end
      2'b01: begin p = sa * sb; {hi, lo} = p; end
      2'b10: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo = a; hi = '0; end
        else begin lo = ia / ib; hi = ia % ib; end
      end
    endcase
  endfunction

  // Drive one start pulse; returns at the falling edge after the start edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.data0_i = a;
    bus.data1_i = b;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    while (bus.done_o !== 1'b1 && lat < 100) begin
      if (bus.busy_o === 1'b1) busyCycles++;
      @(negedge clk);
      lat++;
    end
    if (bus.busy_o === 1'b1) busyCycles++;
  endtask

  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo, input string tag);
    int lat, busyCycles, expLat;
    applyStimulus(op, a, b);
    waitDone(lat, busyCycles);
    expLat = (!op[1] && FAST) ? 0 : W + 1;
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'(expLat + 1));
    checkOutput({tag, " hi"}, 64'(bus.hi_o), 64'(expHi));
    checkOutput({tag, " lo"}, 64'(bus.lo_o), 64'(expLo));
    @(negedge clk);
    checkOutput({tag, " done/busy after"}, {62'h0, bus.done_o, bus.busy_o}, 64'h0);
    modelHi = expHi;
    modelLo = expLo;
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    int doneCount, lat, busyCycles;
    logic [W-1:0] capHi, capLo, a, b, eh, el;
    logic [1:0] op;
    logic hwe, lwe;

    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.data0_i = '0; bus.data1_i = '0;
    bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0; bus.wdata_i = '0;

    #1;
    checkOutput("reset state", {bus.hi_o, bus.lo_o}, 64'h0);
    checkOutput("reset status", {62'h0, bus.busy_o, bus.done_o}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed operations");
    runOp(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "MULTU max");
    runOp(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "MULT -3*5");
    runOp(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "DIV -7/2");
    runOp(2'b10, 32'd7, 32'd2, 32'd1, 32'd3, "DIVU 7/2");
    runOp(2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "DIVU 7/0");
    runOp(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "DIV min/-1");
    runOp(2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "DIV -7/0");

    $display("[TB] MTHI on the start edge");
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b10; bus.data0_i = 32'd100; bus.data1_i = 32'd7;
    bus.hi_we_i = 1'b1; bus.wdata_i = 32'hABCD;
    @(negedge clk);
    bus.start_i = 1'b0; bus.hi_we_i = 1'b0;
    checkOutput("MTHI with start hi", 64'(bus.hi_o), 64'h0000ABCD);
    checkOutput("MTHI with start lo", 64'(bus.lo_o), 64'(modelLo));
    waitDone(lat, busyCycles);
    checkOutput("MTHI with start latency", 64'(lat), 64'(W + 1));
    checkOutput("MTHI with start result", {bus.hi_o, bus.lo_o}, {32'd2, 32'd14});

    $display("[TB] MTLO and second start during CALC");
    applyStimulus(2'b10, 32'd9, 32'd3);
    repeat (3) @(negedge clk);
    bus.lo_we_i = 1'b1; bus.wdata_i = 32'h1234;
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.data0_i = 32'd5; bus.data1_i = 32'd5;
    @(negedge clk);
    bus.lo_we_i = 1'b0; bus.start_i = 1'b0;
    checkOutput("MTLO in CALC", 64'(bus.lo_o), 64'h1234);
    doneCount = 0; capHi = '0; capLo = '0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done_o === 1'b1) begin
        doneCount++;
        capHi = bus.hi_o;
        capLo = bus.lo_o;
      end
      @(negedge clk);
    end
    checkOutput("CALC collision done pulses", 64'(doneCount), 64'd1);
    checkOutput("CALC collision result", {capHi, capLo}, {32'd0, 32'd3});
    checkOutput("CALC collision idle after", {63'h0, bus.busy_o}, 64'h0);
    modelHi = 32'd0; modelLo = 32'd3;

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3));
      a = pickOperand();
      b = pickOperand();
      computeRef(op, a, b, eh, el);
      runOp(op, a, b, eh, el, $sformatf("rand%0d op%0d", n, op));
      hwe = 1'($urandom_range(0, 1));
      lwe = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.hi_we_i = hwe; bus.lo_we_i = lwe; bus.wdata_i = 32'($urandom());
      if (hwe) modelHi = bus.wdata_i;
      if (lwe) modelLo = bus.wdata_i;
      @(negedge clk);
      bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0;
      checkOutput($sformatf("rand%0d mthi/mtlo", n), {bus.hi_o, bus.lo_o}, {modelHi, modelLo});
    end

    $display("[TB] reset during MULT");
    @(negedge clk);
    bus.hi_we_i = 1'b1; bus.lo_we_i = 1'b1; bus.wdata_i = 32'h55;
    @(negedge clk);
    bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0;
    checkOutput("preload", {bus.hi_o, bus.lo_o}, {32'h55, 32'h55});
    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 2'b01; bus.data0_i = 32'd1000; bus.data1_i = 32'hFFFFFFFE;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset hi/lo", {bus.hi_o, bus.lo_o}, 64'h0);
    checkOutput("async reset status", {62'h0, bus.busy_o, bus.done_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) doneCount++;
    end
    checkOutput("no done after reset", 64'(doneCount), 64'd0);
    checkOutput("hi/lo after reset", {bus.hi_o, bus.lo_o}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the next-generation MIPS core.
- Implements MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers, including the MTHI/MTLO write paths.
- Sits beside the ALU in the execute stage.
- The core launches an operation with start_i, stalls on busy_o, and reads HI/LO once done_o has pulsed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Legal values: 8 or more, even.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; not overridden).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  launch request; sampled only in IDLE.
- op_i  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- data0_i  input  WIDTH  rs operand (multiplicand or dividend).
- data1_i  input  WIDTH  rt operand (multiplier or divisor).
- hi_we_i  input  1  MTHI write enable.
- lo_we_i  input  1  MTLO write enable.
- wdata_i  input  WIDTH  MTHI/MTLO write data.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle pulse; HI/LO are valid from this cycle on.
- hi_o  output  WIDTH  HI register.
- lo_o  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0; counter and working registers cleared. An in-flight operation is discarded and produces no done_o.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE -> CALC: on an edge with start_i=1. The edge latches op_i and the operand magnitudes, plus the sign flags for signed ops (MULT/DIV). Counter set to 0.
- CALC:
  - one radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide.
  - after WIDTH edges the state moves to FIXUP.
- FIXUP: one edge applies two's-complement sign correction.
  - MULT: product negated if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend; quotient truncates toward zero.
- DONE: entered on the FIXUP edge; that same edge loads HI and LO.
  - Multiply: {HI,LO} = 2*WIDTH-bit product.
  - Divide: LO = quotient, HI = remainder.
  - done_o=1 for exactly this one cycle; the next edge returns to IDLE.
- Latency: start edge E0; done_o is high in the cycle after edge E0+WIDTH+1. For WIDTH=32 that is 34 edges, counting E0.
- start_i outside IDLE is ignored, with no queuing. start_i in DONE is also ignored.
- Divide by zero (signed and unsigned): LO = all ones, HI = data0_i as latched. Same latency as a normal divide; no exception flag.
- Signed overflow DIV MIN/-1: LO = MIN, HI = 0.
- MTHI/MTLO:
  - hi_we_i/lo_we_i update HI/LO on the edge, in any state.
  - The DONE-entry result write has priority over a simultaneous MTHI/MTLO write.
  - A write that lands during CALC/FIXUP is overwritten by the result.
- start_i and hi_we_i on the same IDLE edge: both take effect. Operands come from data0_i/data1_i, not from wdata_i.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- When defined:
  - MULT/MULTU compute the product combinationally and go IDLE -> DONE on the start edge.
  - done_o is high in the cycle after E0.
  - CALC and FIXUP are skipped for multiplies.
  - Divide behaviour is unchanged.
- When undefined: all ops use the iterative path described above.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV;
  - the state enum (IDLE, CALC, FIXUP, DONE);
  - the default WIDTH constant.
- The control decoder imports the op encodings from this package.
- One natural sub-module: mdu_negate (a WIDTH-parameterised conditional two's-complement). It is instantiated for operand magnitude on entry and for the sign fix in FIXUP.
- Everything else stays in mdu_iter.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> done_o in the cycle after edge E0+33; HI=0xFFFFFFFE, LO=0x00000001; busy_o high for 34 cycles.
- MULT -3 * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; with MDU_FAST_MUL_EN, done_o in the cycle after E0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
- DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0x1234 during CALC of DIVU 9/3, plus a second start_i pulse in CALC -> LO=3, HI=0 at done; exactly one done_o pulse.
- Preload HI=LO=0x55 via MTHI/MTLO, start MULT, assert rst_i at edge E0+10 -> hi_o=lo_o=0 and busy_o=0 immediately; no done_o afterwards.
